router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet transmitter for the router 1x3 input port. It accepts a destination address, a payload length and a stream of payload bytes, and buffers the payload internally. It then drives a complete packet into the router's `packet_valid`/`data_in` interface: header `{len, addr}`, the payload bytes, and an XOR parity byte. While the router asserts `busy`, it holds the current byte stable.

## Interface
- `MAX_LEN`, 63: maximum payload length in bytes. Sets buffer depth; the length field is 6 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  packet request; sampled only in IDLE.
- `dest_addr`  in  2  destination port 0..2; 3 is invalid.
- `payload_len`  in  6  payload byte count 1..63; 0 is invalid.
- `corrupt_parity`  in  1  test hook, sampled with `start`; transmits `~parity`.
- `pl_data`  in  8  payload byte.
- `pl_valid`  in  1  `pl_data` valid.
- `pl_ready`  out  1  payload byte accepted when `pl_valid & pl_ready`.
- `busy`  in  1  router back-pressure; the current byte is held while high.
- `packet_valid`  out  1  high for the header and payload beats, low for the parity beat.
- `data_in`  out  8  byte to the router; registered.
- `tx_busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the parity beat transfers.
- `cfg_err`  out  1  one-cycle pulse when a `start` carries an invalid addr or len.

## Operation
- **Reset values:** state IDLE; `packet_valid`, `data_in`, `pl_ready`, `tx_busy`, `done`, `cfg_err`, counters and parity all 0.
- **States:** IDLE, LOAD, HEADER, PAYLOAD, PARITY.
- **IDLE**
  - On `start` with a valid addr and len: capture addr, len and the corrupt flag; clear parity and `wr_cnt`; go to LOAD.
  - On `start` with addr==3 or len==0: pulse `cfg_err` and stay in IDLE.
  - `start` in any state other than IDLE is ignored.
- **LOAD**
  - `pl_ready`=1, decoded from the state register.
  - On each accepted byte: write `buf[wr_cnt]`, `parity ^= pl_data`, increment `wr_cnt`.
  - On the byte where `wr_cnt==len-1`:
    - `data_in<={len,addr}` and `packet_valid<=1`.
    - Fold the header into parity.
    - Go to HEADER.
  - `pl_ready` drops in the same edge.
- **Beat rule:** a beat transfers on a rising edge in HEADER, PAYLOAD or PARITY with `busy==0`. With `busy==1`, `data_in`, `packet_valid` and the state hold.
- **HEADER:** on transfer, `data_in<=buf[0]`, `rd_cnt<=1`, go to PAYLOAD.
- **PAYLOAD:** on transfer:
  - If `rd_cnt==len`: `data_in<=` parity (inverted if the corrupt flag is set), `packet_valid<=0`, go to PARITY.
  - Otherwise: `data_in<=buf[rd_cnt]`, increment `rd_cnt`.
- **PARITY:** on transfer, `data_in<=0`, `done<=1` for one cycle, go to IDLE.
- **Parity:** 8-bit XOR of the header and all payload bytes.
- **Counters:** 6-bit, no wrap, because len ≤ 63.
- **Reset mid-packet:** outputs clear immediately (asynchronous), the packet is abandoned, and buffer contents are don't-care.

## Timing
- The header appears on `data_in` in the cycle after the last payload byte is accepted.
- With `busy` low throughout, beats are back-to-back: 1 header cycle, `len` payload cycles, then 1 parity cycle.
  - `packet_valid` is high for exactly `len+1` cycles.
  - `done` pulses in the cycle after the parity beat.
- Minimum IDLE→IDLE time is `1 + len + 1 + len + 1` cycles.
- A new `start` is accepted in the cycle `done` is high.
- Each cycle of `busy` stretches the current beat by one cycle; no byte is dropped or duplicated.

## Structure
- Shared package `router_pkg`:
  - state enum
  - `ADDR_W=2`, `LEN_W=6`, `DATA_W=8`
  - `ADDR_INVALID=2'b11`
  - header pack function `{len,addr}`
- Sub-module `router_tx_buf`: `MAX_LEN`×8 storage with synchronous write and combinational read by `rd_cnt`.
- The top level holds the FSM, counters, parity register and output registers.

## Test plan
- **Reset values:** assert `reset` mid-cycle → all outputs 0 immediately; IDLE after release.
- **Nominal packet:** `start`, addr=2, len=14, payload 0x01..0x0E, `busy`=0 →
  - `data_in` sequence 0x3A, 0x01..0x0E, then parity 0x35;
  - `packet_valid` high for 15 cycles and low on the parity beat;
  - `done` pulses once.
- **Back-pressure:** same packet with `busy`=1 for 3 cycles while byte 0x05 is on `data_in` → 0x05 held for 4 cycles, then 0x06; sequence unchanged, completion 3 cycles later.
- **Corrupt parity:** same packet with `corrupt_parity`=1 → parity beat 0xCA; all other beats identical.
- **Invalid config:** `start` with addr=3, or with len=0 → `cfg_err` pulses for 1 cycle, `tx_busy` stays 0, `pl_ready` stays 0, no `packet_valid`.
- **Reset mid-packet:** reset during PAYLOAD (byte 7) → `packet_valid`/`data_in` go to 0 immediately. A following addr=0, len=1, payload 0xFF packet yields 0x04, 0xFF, parity 0xFB.

Source files
------------

// File: rtl/router_pkt_tx_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4
  } tx_state_e;

  // Header byte as the router expects it: length in the upper six bits,
  // destination port in the lower two.
  function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Bundle of the request, payload stream and router-side signals.
//
// Handshakes:
//   payload: a byte moves on a rising edge where pl_valid & pl_ready are both
//            high; the producer holds pl_data stable while pl_valid is high and
//            pl_ready is low, and pl_ready does not depend on pl_valid.
//   router : a beat moves on a rising edge in HEADER/PAYLOAD/PARITY where busy
//            is low; while busy is high data_in and packet_valid hold.
interface router_pkt_tx_if;
  import router_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] dest_addr;
  logic [LEN_W-1:0]  payload_len;
  logic              corrupt_parity;
  logic [DATA_W-1:0] pl_data;
  logic              pl_valid;
  logic              pl_ready;
  logic              busy;
  logic              packet_valid;
  logic [DATA_W-1:0] data_in;
  logic              tx_busy;
  logic              done;
  logic              cfg_err;
  tx_state_e         dbg_state;

  modport master (
    output start, dest_addr, payload_len, corrupt_parity, pl_data, pl_valid, busy,
    input  pl_ready, packet_valid, data_in, tx_busy, done, cfg_err, dbg_state
  );

  modport slave (
    input  start, dest_addr, payload_len, corrupt_parity, pl_data, pl_valid, busy,
    output pl_ready, packet_valid, data_in, tx_busy, done, cfg_err, dbg_state
  );

endinterface

// File: rtl/router_pkt_tx_buf.sv
// Payload buffer: one byte per entry, synchronous write, combinational read.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [MAX_LEN];

  // Store accepted payload bytes; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < MAX_LEN)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port follows the transmit counter; out-of-range reads return zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < MAX_LEN) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the router input port: buffers a payload, then sends
// header, payload and XOR parity with back-pressure from the router.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63
) (
  input logic             clk,
  input logic             reset,
  router_pkt_tx_if.slave  bus
);

  tx_state_e         state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              corrupt_q;
  logic [DATA_W-1:0] parity_q;
  logic [LEN_W-1:0]  wr_cnt;
  logic [LEN_W-1:0]  rd_cnt;
  logic [DATA_W-1:0] data_q;
  logic              pv_q;
  logic              done_q;
  logic              cfg_err_q;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [DATA_W-1:0] header;

  assign wr_en  = (state == S_LOAD) && bus.pl_valid;
  assign header = pack_header(len_q, addr_q);

  router_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt),
    .wr_data (bus.pl_data),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  // Transmit FSM with counters, parity accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      corrupt_q <= 1'b0;
      parity_q  <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      data_q    <= '0;
      pv_q      <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            if ((bus.dest_addr == ADDR_INVALID) || (bus.payload_len == '0)) begin
              cfg_err_q <= 1'b1;
            end else begin
              addr_q    <= bus.dest_addr;
              len_q     <= bus.payload_len;
              corrupt_q <= bus.corrupt_parity;
              parity_q  <= '0;
              wr_cnt    <= '0;
              // rd_cnt starts at 0 so the buffer already presents byte 0 in HEADER.
              rd_cnt    <= '0;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.pl_valid) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == len_q - 6'd1) begin
              data_q   <= header;
              pv_q     <= 1'b1;
              parity_q <= parity_q ^ bus.pl_data ^ header;
              state    <= S_HEADER;
            end else begin
              parity_q <= parity_q ^ bus.pl_data;
            end
          end
        end
        S_HEADER: begin
          if (!bus.busy) begin
            data_q <= rd_data;
            rd_cnt <= rd_cnt + 6'd1;
            state  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!bus.busy) begin
            if (rd_cnt == len_q) begin
              data_q <= corrupt_q ? ~parity_q : parity_q;
              pv_q   <= 1'b0;
              state  <= S_PARITY;
            end else begin
              data_q <= rd_data;
              rd_cnt <= rd_cnt + 6'd1;
            end
          end
        end
        S_PARITY: begin
          if (!bus.busy) begin
            data_q <= '0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pl_ready     = (state == S_LOAD);
  assign bus.tx_busy      = (state != S_IDLE);
  assign bus.packet_valid = pv_q;
  assign bus.data_in      = data_q;
  assign bus.done         = done_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed testbench for router_pkt_tx: nominal, back-pressure, corrupt
// parity, invalid config and reset-mid-packet scenarios.
module tb_router_pkt_tx;
  import router_pkg::*;

  logic clk;
  logic reset;

  int n_checks;
  int n_errors;

  logic [7:0] pl_mem [64];

  router_pkt_tx_if bus ();

  router_pkt_tx #(.MAX_LEN(63)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  // Single comparison point.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start          = 1'b0;
    bus.dest_addr      = '0;
    bus.payload_len    = '0;
    bus.corrupt_parity = 1'b0;
    bus.pl_data        = '0;
    bus.pl_valid       = 1'b0;
    bus.busy           = 1'b0;
  endtask

  // Sends one packet and checks every beat cycle by cycle.
  // busy_beat: beat index held with busy for busy_cycles (-1 = none).
  // abort_beat: beat index during which reset is pulsed (-1 = none).
  task automatic send_packet(input logic [1:0] addr, input logic [5:0] len,
                             input logic corrupt, input logic [7:0] exp_hdr,
                             input logic [7:0] exp_par, input int busy_beat,
                             input int busy_cycles, input int abort_beat);
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    exp_q.push_back(exp_hdr);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(pl_mem[i]);
    exp_q.push_back(exp_par);

    @(posedge clk); #1;
    bus.start          = 1'b1;
    bus.dest_addr      = addr;
    bus.payload_len    = len;
    bus.corrupt_parity = corrupt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("load_pl_ready", 32'(bus.pl_ready), 32'd1);
    check_eq("load_tx_busy", 32'(bus.tx_busy), 32'd1);
    check_eq("load_pv", 32'(bus.packet_valid), 32'd0);

    for (int i = 0; i < int'(len); i++) begin
      bus.pl_valid = 1'b1;
      bus.pl_data  = pl_mem[i];
      @(posedge clk); #1;
    end
    bus.pl_valid = 1'b0;
    bus.pl_data  = '0;
    check_eq("hdr_pl_ready", 32'(bus.pl_ready), 32'd0);

    for (int j = 0; j <= int'(len) + 1; j++) begin
      exp_b = exp_q.pop_front();
      if (j == abort_beat) begin
        check_eq("abort_data", 32'(bus.data_in), 32'(exp_b));
        #1 reset = 1'b1;
        #1;
        check_eq("rst_pv", 32'(bus.packet_valid), 32'd0);
        check_eq("rst_data", 32'(bus.data_in), 32'd0);
        check_eq("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
        check_eq("rst_pl_ready", 32'(bus.pl_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
        return;
      end
      if (j == busy_beat) begin
        bus.busy = 1'b1;
        for (int k = 0; k < busy_cycles; k++) begin
          @(negedge clk);
          check_eq("busy_hold_data", 32'(bus.data_in), 32'(exp_b));
          check_eq("busy_hold_pv", 32'(bus.packet_valid), 32'(j <= int'(len)));
          @(posedge clk); #1;
        end
        bus.busy = 1'b0;
      end
      @(negedge clk);
      check_eq($sformatf("beat%0d_data", j), 32'(bus.data_in), 32'(exp_b));
      check_eq($sformatf("beat%0d_pv", j), 32'(bus.packet_valid), 32'(j <= int'(len)));
      @(posedge clk); #1;
    end

    @(negedge clk);
    check_eq("done_pulse", 32'(bus.done), 32'd1);
    check_eq("done_pv", 32'(bus.packet_valid), 32'd0);
    check_eq("done_data", 32'(bus.data_in), 32'd0);
    check_eq("done_tx_busy", 32'(bus.tx_busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("done_clear", 32'(bus.done), 32'd0);
  endtask

  task automatic bad_start(input logic [1:0] addr, input logic [5:0] len);
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.dest_addr   = addr;
    bus.payload_len = len;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("cfg_err_pulse", 32'(bus.cfg_err), 32'd1);
    check_eq("cfg_tx_busy", 32'(bus.tx_busy), 32'd0);
    check_eq("cfg_pl_ready", 32'(bus.pl_ready), 32'd0);
    check_eq("cfg_pv", 32'(bus.packet_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("cfg_err_clear", 32'(bus.cfg_err), 32'd0);
    check_eq("cfg_tx_busy2", 32'(bus.tx_busy), 32'd0);
    check_eq("cfg_state", 32'(bus.dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_pv", 32'(bus.packet_valid), 32'd0);
    check_eq("reset_data", 32'(bus.data_in), 32'd0);
    check_eq("reset_pl_ready", 32'(bus.pl_ready), 32'd0);
    check_eq("reset_tx_busy", 32'(bus.tx_busy), 32'd0);
    check_eq("reset_done", 32'(bus.done), 32'd0);
    check_eq("reset_cfg_err", 32'(bus.cfg_err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("reset_state", 32'(bus.dbg_state), 32'(S_IDLE));

    for (int i = 0; i < 14; i++) pl_mem[i] = 8'(i + 1);

    // Nominal: addr 2, len 14 -> header 0x3A, parity 0x35.
    send_packet(2'd2, 6'd14, 1'b0, 8'h3A, 8'h35, -1, 0, -1);
    // Back-pressure: 0x05 (beat 5) held for 3 extra cycles.
    send_packet(2'd2, 6'd14, 1'b0, 8'h3A, 8'h35, 5, 3, -1);
    // Back-pressure on header and parity beats.
    send_packet(2'd2, 6'd14, 1'b0, 8'h3A, 8'h35, 0, 2, -1);
    send_packet(2'd2, 6'd14, 1'b0, 8'h3A, 8'h35, 15, 2, -1);
    // Corrupt parity -> 0xCA.
    send_packet(2'd2, 6'd14, 1'b1, 8'h3A, 8'hCA, -1, 0, -1);
    // Invalid configs.
    bad_start(2'd3, 6'd5);
    bad_start(2'd1, 6'd0);
    // Reset while byte 0x07 is on data_in.
    send_packet(2'd2, 6'd14, 1'b0, 8'h3A, 8'h35, -1, 0, 7);
    // Minimal packet after reset: addr 0, len 1, 0xFF -> 0x04, 0xFF, 0xFB.
    pl_mem[0] = 8'hFF;
    send_packet(2'd0, 6'd1, 1'b0, 8'h04, 8'hFB, -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
